oh_rrarb6: RTL and testbench

OH_RRARB6 -- requirements
Module: oh_rrarb6

---
 rtl/oh_rrarb6.sv | 141 ++++++++++++++
 tb/tb_oh_rrarb6.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/oh_rrarb6.sv
// oh_rrarb6: six-way round-robin packet arbiter with one-hot data mux.
// Ports: clk/reset (sync, active high), en, valid_in/last_in/in0..in5 per
// requester, ready_out per requester, out/out_valid/out_last/out_ready
// toward downstream, grant (registered one-hot), busy.
module oh_rrarb6 #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [5:0]    valid_in,
    input  logic [5:0]    last_in,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [DW-1:0] in4,
    input  logic [DW-1:0] in5,
    output logic [5:0]    ready_out,
    output logic [DW-1:0] out,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic [5:0]    grant,
    output logic          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [5:0]    grant_q;
    logic [5:0]    grant_d;
    logic [2:0]    ptr_q;
    logic [2:0]    ptr_d;

    logic [DW-1:0] data [6];
    logic [5:0]    pick;
    logic          found;
    logic [3:0]    slot;
    logic [2:0]    gidx;
    logic [2:0]    next_ptr;
    logic          last_xfer;

    assign data[0] = in0;
    assign data[1] = in1;
    assign data[2] = in2;
    assign data[3] = in3;
    assign data[4] = in4;
    assign data[5] = in5;

    // Cyclic search starting at ptr; slot is kept 4 bits wide so
    // ptr + offset (max 10) folds back into 0..5 without overflow.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        slot  = '0;
        for (int k = 0; k < 6; k++) begin
            slot = {1'b0, ptr_q} + 4'(k);
            if (slot >= 4'd6) begin
                slot = slot - 4'd6;
            end
            if (!found && valid_in[slot[2:0]]) begin
                pick[slot[2:0]] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    // Encode the held one-hot grant back to an index for pointer update.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < 6; i++) begin
            if (grant_q[i]) begin
                gidx = gidx | 3'(i);
            end
        end
    end

    assign next_ptr = (gidx == 3'd5) ? 3'd0 : gidx + 3'd1;

    // Datapath is purely combinational off the registered grant, so an
    // idle arbiter (grant = 0) forces every downstream output to zero.
    always_comb begin
        out = '0;
        for (int i = 0; i < 6; i++) begin
            if (grant_q[i]) begin
                out = out | data[i];
            end
        end
    end

    assign out_valid = |(grant_q & valid_in);
    assign out_last  = |(grant_q & valid_in & last_in);
    assign ready_out = grant_q & {6{out_ready}};
    assign last_xfer = out_valid & out_ready & out_last;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (en && (|valid_in)) begin
                    state_d = BUSY;
                    grant_d = pick;
                end
            end
            BUSY: begin
                if (last_xfer) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == BUSY);

endmodule

// File: tb/tb_oh_rrarb6.sv
// tb_oh_rrarb6: directed and random checks of oh_rrarb6 against a
// behavioural round-robin model.
module tb_oh_rrarb6;

    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic          en;
    logic [5:0]    valid_in;
    logic [5:0]    last_in;
    logic [DW-1:0] d [6];
    logic [5:0]    ready_out;
    logic [DW-1:0] out;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [5:0]    grant;
    logic          busy;

    oh_rrarb6 #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .in0       (d[0]),
        .in1       (d[1]),
        .in2       (d[2]),
        .in3       (d[3]),
        .in4       (d[4]),
        .in5       (d[5]),
        .ready_out (ready_out),
        .out       (out),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: busy flag, granted requester index, round-robin start index.
    bit m_busy = 0;
    int m_g    = 0;
    int m_ptr  = 0;
    int m_beats = 0;
    int dut_beats = 0;
    int wait_cnt [6];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic e, input logic [5:0] v,
                       input logic [5:0] l, input logic r,
                       input logic rs);
        logic [5:0]    pg;
        logic [5:0]    eg;
        logic [DW-1:0] eo;
        bit            ev;
        bit            el;
        bit            late;
        int            cnt;
        int            gi;
        @(negedge clk);
        en        = e;
        valid_in  = v;
        last_in   = l;
        out_ready = r;
        reset     = rs;
        for (int i = 0; i < 6; i++) d[i] = DW'($urandom);
        #1;
        ev = m_busy && v[m_g];
        el = ev && l[m_g];
        eo = m_busy ? d[m_g] : '0;
        eg = m_busy ? 6'(1 << m_g) : 6'd0;
        check("out_valid", out_valid, ev);
        check("out_last", out_last, el);
        check("out", out, eo);
        check("ready_out", ready_out, r ? eg : 6'd0);
        for (int i = 0; i < 6; i++)
            if (ready_out[i] && valid_in[i]) dut_beats++;
        if (ev && r) m_beats++;
        pg = grant;
        @(posedge clk);
        if (rs) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            if (e && v != 0) begin
                for (int k = 5; k >= 0; k--)
                    if (v[(m_ptr + k) % 6]) m_g = (m_ptr + k) % 6;
                m_busy = 1;
            end
        end else if (ev && el && r) begin
            m_busy = 0;
            m_ptr  = (m_g + 1) % 6;
        end
        #1;
        check("grant", grant, m_busy ? 6'(1 << m_g) : 6'd0);
        check("busy", busy, m_busy);
        check("onehot", $countones(grant) <= 1, 1);
        if (rs) begin
            for (int i = 0; i < 6; i++) wait_cnt[i] = 0;
        end else if (pg == 0 && grant != 0) begin
            late = 0;
            gi   = -1;
            for (int i = 0; i < 6; i++) if (grant[i]) gi = i;
            for (int i = 0; i < 6; i++) begin
                if (v[i] && i != gi) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > 5) late = 1;
            end
            check("fair", late, 0);
        end
        cnt = 0;
    endtask

    task automatic rst();
        cyc(1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
    endtask

    logic [4:0] rdy_seq;
    int         b0;
    int         sent;

    initial begin
        en = 0; valid_in = 0; last_in = 0; out_ready = 0; reset = 1;
        for (int i = 0; i < 6; i++) begin
            d[i] = '0;
            wait_cnt[i] = 0;
        end
        rst();
        check("rst_grant", grant, 6'd0);
        check("rst_ready", ready_out, 6'd0);

        // two requesters, single-beat packets, then ptr wraps to 0
        cyc(1, 6'b100001, 6'h3f, 1, 0);
        check("d32_g0", grant, 6'b000001);
        cyc(1, 6'b100001, 6'h3f, 1, 0);
        check("d32_bub", grant, 6'd0);
        cyc(1, 6'b100001, 6'h3f, 1, 0);
        check("d32_g5", grant, 6'b100000);
        cyc(1, 6'b100001, 6'h3f, 1, 0);
        cyc(1, 6'b100001, 6'h3f, 1, 0);
        check("d32_wrap", grant, 6'b000001);

        // all six continuously: grants rotate with one bubble each
        rst();
        for (int k = 0; k < 14; k++) begin
            cyc(1, 6'h3f, 6'h3f, 1, 0);
            check("d33_rot", grant,
                  (k % 2 == 0) ? 6'(1 << ((k / 2) % 6)) : 6'd0);
        end

        // 3-beat packet on requester 2 with stalls; 4 ignored while busy
        rst();
        cyc(1, 6'b000100, 6'd0, 1, 0);
        check("d34_g2", grant, 6'b000100);
        rdy_seq = 5'b10101;
        sent = 0;
        b0 = dut_beats;
        for (int j = 0; j < 5; j++) begin
            cyc(1, 6'b010100, (sent == 2) ? 6'b000100 : 6'd0,
                rdy_seq[j], 0);
            check("d34_hold", grant, (j < 4) ? 6'b000100 : 6'd0);
            if (rdy_seq[j]) sent++;
        end
        check("d34_beats", dut_beats - b0, 3);
        cyc(1, 6'b010100, 6'd0, 1, 0);
        check("d34_g4", grant, 6'b010000);

        // en low blocks arbitration
        rst();
        for (int k = 0; k < 10; k++) begin
            cyc(0, 6'h3f, 6'h3f, 1, 0);
            check("d35_en0", grant, 6'd0);
        end
        cyc(1, 6'h3f, 6'h3f, 1, 0);
        check("d35_en1", grant, 6'b000001);

        // reset mid-packet on requester 3
        rst();
        cyc(1, 6'b001000, 6'd0, 1, 0);
        cyc(1, 6'b001000, 6'd0, 1, 0);
        check("d36_g3", grant, 6'b001000);
        cyc(1, 6'b001000, 6'd0, 1, 1);
        check("d36_grant", grant, 6'd0);
        check("d36_busy", busy, 0);
        check("d36_rdy", ready_out, 6'd0);
        cyc(1, 6'h3f, 6'd0, 1, 0);
        check("d36_ptr", grant, 6'b000001);

        // reset beats a simultaneous last transfer
        rst();
        cyc(1, 6'b001000, 6'd0, 1, 0);
        cyc(1, 6'b001000, 6'b001000, 1, 1);
        cyc(1, 6'h3f, 6'd0, 1, 0);
        check("rst_prio", grant, 6'b000001);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom % 8) != 0,
                6'($urandom) | 6'($urandom),
                6'($urandom) & 6'($urandom),
                ($urandom % 4) != 0,
                ($urandom % 300) == 0);
        end
        check("beats", dut_beats, m_beats);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
